// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter sharing the register-file write port among NREQ writers.
// Optional owner locking (ARB/LOCKED FSM bounded by MAX_LOCK) is enabled by defining RF_ARB_LOCK_EN.
module rf_write_arbiter #(
  parameter int BW       = 16,
  parameter int DEPTH    = 32,
  parameter int NREQ     = 3,
  parameter int MAX_LOCK = 8,
  localparam int AW      = $clog2(DEPTH),
  localparam int GW      = $clog2(NREQ)
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               arb_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*BW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rf_chip_en,
  output logic               rf_write_en_n,
  output logic [AW-1:0]      rf_write_addr,
  output logic [BW-1:0]      rf_data_in,
  output logic [GW-1:0]      grant_id,
  output logic               lock_active
);

  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic            chip_en_q, chip_en_d;
  logic            write_en_n_q, write_en_n_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   data_q, data_d;
  logic [GW-1:0]   rr_sel, xfer_id;
  logic            rr_found, grant_ok, xfer;
  logic [NREQ-1:0] ready;
  int unsigned     cand;

`ifdef RF_ARB_LOCK_EN
  localparam int LW = $clog2(MAX_LOCK + 1);
  typedef enum logic {ARB, LOCKED} state_e;
  state_e          state_q, state_d;
  logic [GW-1:0]   owner_q, owner_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
`endif

  function automatic logic [GW-1:0] inc_ptr(input logic [GW-1:0] p);
    return (p == GW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    rr_sel   = rr_ptr_q;
    rr_found = 1'b0;
    cand     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % NREQ;
      if (!rr_found && req_valid[GW'(cand)]) begin
        rr_found = 1'b1;
        rr_sel   = GW'(cand);
      end
    end
  end

  always_comb begin
    ready    = '0;
    grant_ok = arb_en && rst_n;
    xfer_id  = rr_sel;
`ifdef RF_ARB_LOCK_EN
    if (state_q == LOCKED) begin
      xfer_id        = owner_q;
      ready[owner_q] = req_valid[owner_q] && grant_ok;
    end else begin
      ready[rr_sel] = rr_found && grant_ok;
    end
`else
    ready[rr_sel] = rr_found && grant_ok;
`endif
  end

  assign xfer      = |ready;
  assign req_ready = ready;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    chip_en_d    = 1'b0;
    write_en_n_d = 1'b1;
    addr_d       = addr_q;
    data_d       = data_q;
    if (xfer) begin
      rr_ptr_d     = inc_ptr(xfer_id);
      grant_id_d   = xfer_id;
      chip_en_d    = 1'b1;
      write_en_n_d = 1'b0;
      addr_d       = req_addr[xfer_id*AW +: AW];
      data_d       = req_data[xfer_id*BW +: BW];
    end
`ifdef RF_ARB_LOCK_EN
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (state_q == ARB) begin
      if (xfer && req_lock[xfer_id] && MAX_LOCK > 1) begin
        state_d    = LOCKED;
        owner_d    = xfer_id;
        lock_cnt_d = LW'(1);
      end
    end else if (!req_valid[owner_q] ||
                 (xfer && (!req_lock[owner_q] || int'(lock_cnt_q) + 1 >= MAX_LOCK))) begin
      // The final locked transfer is still accepted; the pointer moves past the owner.
      state_d    = ARB;
      lock_cnt_d = '0;
      rr_ptr_d   = inc_ptr(owner_q);
    end else if (xfer) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      chip_en_q    <= 1'b0;
      write_en_n_q <= 1'b1;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      chip_en_q    <= chip_en_d;
      write_en_n_q <= write_en_n_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

`ifdef RF_ARB_LOCK_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign lock_active = (state_q == LOCKED);
`else
  logic unused_lock;
  assign unused_lock = ^req_lock ^ (MAX_LOCK > 1);
  assign lock_active = 1'b0;
`endif

  assign rf_chip_en    = chip_en_q;
  assign rf_write_en_n = write_en_n_q;
  assign rf_write_addr = addr_q;
  assign rf_data_in    = data_q;
  assign grant_id      = grant_id_q;

endmodule
